// File: rtl/pulse_pkg.sv
// Shared pulse front-end parameters and generator state encoding.
// Used by pulse_gen and pulse_filter.
package pulse_pkg;

  localparam int CH_NUM = 32;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    DONE
  } pg_state_t;

endpackage

// File: rtl/pulse_phase_cnt.sv
// Loadable down-counter timing one pulse phase.
// expire is high on the last cycle of a phase of length value.
module pulse_phase_cnt
  import pulse_pkg::*;
#(
  parameter int W = LEN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Parks at zero so a long phase never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/pulse_gen.sv
// Programmable multi-channel pulse-train generator.
// Emits N masked high/low pulses then strobes done.
module pulse_gen #(
  parameter int CH_NUM = pulse_pkg::CH_NUM,
  parameter int LEN_W  = pulse_pkg::LEN_W,
  parameter int CNT_W  = pulse_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CH_NUM-1:0] pulse_mask,
  input  logic [LEN_W-1:0]  high_len,
  input  logic [LEN_W-1:0]  low_len,
  input  logic [CNT_W-1:0]  pulse_num,
  output logic [CH_NUM-1:0] pulse_out,
  output logic              busy,
  output logic              done
);

  import pulse_pkg::*;

  pg_state_t         state;
  logic [CH_NUM-1:0] mask_q;
  logic [LEN_W-1:0]  high_q;
  logic [LEN_W-1:0]  low_q;
  logic [CNT_W-1:0]  pcnt;
  logic [CNT_W-1:0]  rem;
  logic              ok;
  logic              expire;
  logic              load;
  logic [LEN_W-1:0]  load_val;

  assign ok  = start && (high_len != '0) && (pulse_num != '0);
  assign rem = pcnt - CNT_W'(1);

  // Phase reload decision mirrors the FSM transitions below
  always_comb begin
    load     = 1'b0;
    load_val = high_q;
    unique case (state)
      IDLE: begin
        if (ok) begin
          load     = 1'b1;
          load_val = high_len;
        end
      end
      HIGH: begin
        if (!abort && expire) begin
          if (low_q != '0) begin
            load     = 1'b1;
            load_val = low_q;
          end else if (rem != '0) begin
            load = 1'b1;
          end
        end
      end
      LOW: begin
        if (!abort && expire && pcnt != '0) begin
          load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pulse_phase_cnt #(
    .W(LEN_W)
  ) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (load_val),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pulse_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mask_q    <= '0;
      high_q    <= '0;
      low_q     <= '0;
      pcnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ok) begin
            state     <= HIGH;
            pulse_out <= pulse_mask;
            busy      <= 1'b1;
            mask_q    <= pulse_mask;
            high_q    <= high_len;
            low_q     <= low_len;
            pcnt      <= pulse_num;
          end else if (start) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        HIGH: begin
          if (abort) begin
            state     <= DONE;
            pulse_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (expire) begin
            pcnt <= rem;
            if (low_q != '0) begin
              state     <= LOW;
              pulse_out <= '0;
            end else if (rem == '0) begin
              state     <= DONE;
              pulse_out <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        LOW: begin
          if (abort || (expire && pcnt == '0)) begin
            state     <= DONE;
            pulse_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (expire) begin
            state     <= HIGH;
            pulse_out <= mask_q;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pulse_gen.md
# pulse_gen

Programmable 32-channel pulse-train generator: the transmit-side counterpart of `pulse_filter`. On a start request it drives a masked set of `pulse_out` lines high for a programmed number of cycles, low for a programmed gap, and repeats for a programmed pulse count, then signals completion. It feeds `pulse_filter` directly in test and bring-up builds, and is the on-chip stimulus source for the pulse front end at the 20 MHz system clock.

## Interface
- `CH_NUM`, default 32: number of pulse channels.
- `LEN_W`, default 16: width of the high/low length fields.
- `CNT_W`, default 8: width of the pulse-count field.

- `clk`  in  1  system clock (20 MHz).
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  request a pulse train; honoured only in IDLE.
- `abort`  in  1  terminate the train in progress; honoured only in HIGH/LOW.
- `pulse_mask`  in  CH_NUM  channels driven during high phases.
- `high_len`  in  LEN_W  high-phase length in clk cycles.
- `low_len`  in  LEN_W  low-phase (gap) length in clk cycles.
- `pulse_num`  in  CNT_W  number of pulses in the train.
- `pulse_out`  out  CH_NUM  registered pulse outputs.
- `busy`  out  1  train in progress (HIGH or LOW).
- `done`  out  1  one-cycle completion strobe.

## Operation
- The FSM has four states:
  - IDLE: waits for a request.
  - HIGH: `pulse_out` = latched mask.
  - LOW: `pulse_out` = 0.
  - DONE: `done` = 1 for one cycle.
- Reset values: state IDLE, `pulse_out` = 0, `busy` = 0, `done` = 0, all counters and config latches = 0.
- IDLE -> HIGH: when `start` = 1 and both `high_len` and `pulse_num` are non-zero.
  - On that edge, `pulse_mask`, `high_len`, `low_len` and `pulse_num` are latched. Later input changes do not affect the current train.
- IDLE -> DONE: when `start` = 1 and either `high_len` = 0 or `pulse_num` = 0 (degenerate train). No pulse is emitted and `done` still strobes.
- HIGH -> LOW: after `high_len` cycles in HIGH. If `low_len` = 0, the LOW phase is skipped and the next transition applies directly.
- LOW -> HIGH: after `low_len` cycles, if pulses remain.
- LOW -> DONE: after `low_len` cycles on the final pulse. The trailing gap is always emitted.
- With `low_len` = 0 and more than one pulse, the high phases merge: `pulse_out` stays at the mask for `high_len` × `pulse_num` cycles.
- DONE -> IDLE: unconditionally after one cycle. `start` in DONE is ignored.
- `start` while busy is ignored; it is not queued.
- `abort` in HIGH or LOW: `pulse_out` is forced to 0 and the FSM enters DONE on the same edge. `abort` in IDLE or DONE is ignored. `abort` has priority over phase completion on the same edge.
- Pulse counter: counts down from the latched `pulse_num` and decrements at the end of each HIGH phase.
- Phase counter: a LEN_W down-counter reloaded on every phase entry. It never wraps; a phase with length 65535 lasts exactly 65535 cycles.
- `busy` = 1 exactly in HIGH and LOW. `done` = 1 exactly in DONE. They are never both high.
- Assertion of `rst_n` mid-train immediately forces the reset values, with no `done` strobe.

## Timing
- Latency: `pulse_out` takes the mask on the same rising edge that samples `start`. The train is therefore fully registered, with zero cycles of dead time.
- For a train with `start` sampled at edge E:
  - Pulse k (k = 0..N-1) is high from E + k·(H+L) to E + k·(H+L) + H.
  - `busy` is high from E to E + N·(H+L).
  - `done` is high from E + N·(H+L) to E + N·(H+L) + 1.
- Earliest next accepted `start`: edge E + N·(H+L) + 1, i.e. back in IDLE.
- All outputs are direct flop outputs, with no combinational paths from inputs.

## Structure
- Shared package `pulse_pkg` holds:
  - `CH_NUM`, `LEN_W`, `CNT_W` defaults (shared with `pulse_filter`);
  - the state enum `pg_state_t` {IDLE, HIGH, LOW, DONE}.
- One natural sub-module, `pulse_phase_cnt`: a loadable LEN_W down-counter with a `load`/`value`/`expire` interface, reused for the phase timing.
- The pulse counter and FSM stay in the top level.

## Test plan
- mask = 0x0000_0001, H = 10, L = 5, N = 3, `start` at E:
  - `pulse_out[0]` high over [E, E+10), [E+15, E+25), [E+30, E+40);
  - `done` at E+45;
  - all other bits always 0.
- mask = 0xFFFF_FFFF, H = 4, L = 0, N = 2: all bits high continuously for 8 cycles, `done` at E+8. A `start` pulse at E+3 is ignored.
- Degenerate requests: `pulse_num` = 0 (and separately `high_len` = 0) → `pulse_out` never leaves 0, `busy` stays 0, `done` high at E for 1 cycle.
- `abort` asserted at E+12 of the train in the first scenario → `pulse_out` = 0 from E+12, `done` at E+12, IDLE at E+13; a new `start` at E+13 is accepted.
- `rst_n` pulled low at E+7 of the first scenario → `pulse_out`, `busy` and `done` drop to 0 asynchronously, with no `done` strobe. Loopback into `pulse_filter` with `filter_coeff` = 10 and H = 10 shows the pulse passing, while H = 3 shows it suppressed.
